dcache_assoc: RTL and testbench
===============================

Name: dcache_assoc

Overview:
- Parametrised write-back, write-allocate, set-associative data cache between the datapath and the memory controller.
- Successor to the fixed 8-set/2-way/2-word dcache. Set count, associativity and block size are parameters, with true LRU across N ways.
- Multi-word fill and writeback bursts use a word counter.
- On halt it flushes every dirty frame, writes the hit count to memory, then asserts flushed.

Parameters:
- SETS, 8, number of sets; power of two, 2..64.
- WAYS, 2, associativity; 1, 2 or 4.
- BLOCK_WORDS, 2, 32-bit words per block; 1, 2, 4 or 8.
- HIT_CNT_ADDR, 32'h3100, memory address that receives the hit count at halt.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- halt  in  1  datapath halt request.
- dmemREN  in  1  datapath load request.
- dmemWEN  in  1  datapath store request.
- dmemaddr  in  32  datapath byte address; bits [1:0] ignored.
- dmemstore  in  32  store data.
- dhit  out  1  request served this cycle.
- dmemload  out  32  load data, valid while dhit=1.
- flushed  out  1  flush and count write complete.
- dREN  out  1  memory read request.
- dWEN  out  1  memory write request.
- daddr  out  32  memory word address.
- dstore  out  32  memory write data.
- dload  in  32  memory read data.
- dwait  in  1  memory busy; a transfer completes on a cycle with dwait=0 and dREN|dWEN=1.

Behaviour:
- Address fields, LSB first:
  - byte offset: 2 bits.
  - word offset: WO = log2(BLOCK_WORDS) bits.
  - index: IX = log2(SETS) bits.
  - tag: the remaining 30-WO-IX bits.
- Frame contents: valid, dirty, tag, BLOCK_WORDS data words.
- LRU state: each way in each set holds a log2(WAYS)-bit age; 0 means MRU.
  - On an access to way w: every way with age below w's age increments, and w's age becomes 0.
  - After reset, ages are initialised to the way index.
  - For WAYS=1 LRU is omitted.
- Reset (RST=1 at a clock edge): all valid, dirty and LRU state cleared/initialised, hit counter =0, state IDLE. All outputs are 0 in the following cycle. This applies in any state, including mid-burst; no memory transfer is completed.
- The victim is the way with age WAYS-1. An invalid way is preferred over the LRU way, lowest index first.
- Outputs default to 0 in every state.
- IDLE:
  - halt=1 -> FLUSH_CHK, regardless of any request; halt has priority.
  - Otherwise, a request (REN or WEN) whose tag matches a valid way:
    - dhit=1 combinationally in the same cycle.
    - Load: dmemload = the addressed word.
    - Store: word written, dirty set, at the clock edge.
    - LRU updated; hit counter +1 (wraps at 2^32).
  - A miss with a dirty victim -> WB with word counter wc=0. A miss with a clean or invalid victim -> LOAD with wc=0.
  - REN and WEN both high is treated as a store.
- WB:
  - dWEN=1.
  - daddr = {victim tag, index, wc, 2'b00}.
  - dstore = victim word wc.
  - On completion: wc+1. After the last word (wc=BLOCK_WORDS-1): wc=0 -> LOAD.
- LOAD:
  - dREN=1.
  - daddr = {request tag, index, wc, 2'b00}; the fill always starts at word 0.
  - On completion: dload is captured into victim word wc.
  - After the last word: valid=1, dirty=0, tag written -> IDLE. The request then hits next cycle (miss latency = writeback words + BLOCK_WORDS + 1 cycles excluding waits).
  - The hit counter does not count misses.
- FLUSH_CHK: scans flat frame index fi from 0 to SETS*WAYS-1, one frame per cycle.
  - A dirty frame -> FLUSH_WB.
  - After the last frame -> CNT.
- FLUSH_WB:
  - Writes that frame's BLOCK_WORDS words, same addressing as WB.
  - Then clears its dirty bit, increments fi and -> FLUSH_CHK.
- CNT:
  - dWEN=1, daddr=HIT_CNT_ADDR, dstore = hit counter.
  - On completion -> HALTED.
- HALTED: flushed=1, dhit=0. Stays there until RST.
- dwait high for an arbitrary number of cycles holds all memory outputs stable.

Test Plan:
- Reset, then a load at 0x0000_0040 with dload=0xDEAD_0000+addr and dwait low after 2 cycles. Expect:
  - 2 reads, at 0x40 and 0x44.
  - dhit then dmemload=0xDEAD_0040.
  - A second load at 0x44 hits in the same cycle.
- Default parameters: store 0x1111 to 0x40, then loads at 0x240 and 0x440 (same set, different tags). Expect:
  - The 0x440 miss evicts the LRU way. That way holds 0x40, unless 0x40 was touched after 0x240.
  - A dirty victim produces writes at 0x40 (0x1111) then 0x44 before the reads.
- WAYS=4, SETS=4, BLOCK_WORDS=4: fill 5 distinct tags in set 0, re-touching tag 1 before the 5th. Expect the victim is tag 2; the fill is 4 reads at consecutive addresses.
- Three dirty frames, then halt. Expect:
  - Exactly 3×BLOCK_WORDS writes in ascending fi order.
  - Then a write at 0x3100 with data equal to the hit count.
  - Then flushed=1, held.
- RST asserted mid-LOAD (after word 0 completes). Expect next cycle dREN=0 and state IDLE; a re-request at the same address misses and refills.
- halt together with dmemREN in IDLE. Expect dhit=0 and flush begins; a random dwait pattern (0-5 cycles) never changes daddr or dstore while dwait=1.

Source files
------------

// File: rtl/dcache_assoc.sv
// Write-back, write-allocate, set-associative data cache with true LRU.
// Halt flushes every dirty frame, then writes the hit count to memory.
module dcache_assoc #(
    parameter int unsigned SETS         = 8,
    parameter int unsigned WAYS         = 2,
    parameter int unsigned BLOCK_WORDS  = 2,
    parameter logic [31:0] HIT_CNT_ADDR = 32'h3100
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);
    localparam int unsigned WO      = $clog2(BLOCK_WORDS);
    localparam int unsigned IX      = $clog2(SETS);
    localparam int unsigned TW      = 30 - WO - IX;
    localparam int unsigned WOW     = (WO > 0) ? WO : 1;
    localparam int unsigned LW      = $clog2(WAYS);
    localparam int unsigned AW      = (LW > 0) ? LW : 1;
    localparam int unsigned NF      = SETS * WAYS;
    localparam int unsigned FW      = $clog2(NF) + 1;
    localparam int unsigned IX_LSB  = 2 + WO;
    localparam int unsigned TAG_LSB = 2 + WO + IX;

    typedef enum logic [2:0] {
        S_IDLE, S_WB, S_LOAD, S_FLUSH_CHK, S_FLUSH_WB, S_CNT, S_HALTED
    } state_e;

    state_e         state_q, state_d;
    logic [WOW-1:0] wc_q, wc_d;
    logic [FW-1:0]  fi_q, fi_d;
    logic [AW-1:0]  vway_q, vway_d;
    logic [TW-1:0]  mtag_q, mtag_d;
    logic [IX-1:0]  midx_q, midx_d;
    logic [31:0]    hits_q;

    logic           valid_q [SETS][WAYS];
    logic           dirty_q [SETS][WAYS];
    logic [AW-1:0]  age_q   [SETS][WAYS];
    logic [TW-1:0]  tag_q   [SETS][WAYS];
    logic [31:0]    data_q  [SETS][WAYS][BLOCK_WORDS];

    logic [TW-1:0]  req_tag;
    logic [IX-1:0]  req_idx;
    logic [WOW-1:0] req_wo;
    logic [IX-1:0]  fset;
    logic [AW-1:0]  fway;
    logic           unused_addr_bits;

    logic           hit_c, inv_found_c, hit_acc_c, fill_done_c, load_xfer_c, flush_clean_c;
    logic           last_wc_c, touch_c;
    logic [AW-1:0]  hit_way_c, vict_c, touch_way_c;
    logic [IX-1:0]  touch_set_c;

    assign req_tag          = dmemaddr[TAG_LSB +: TW];
    assign req_idx          = dmemaddr[IX_LSB +: IX];
    assign req_wo           = (WO > 0) ? dmemaddr[2 +: WOW] : '0;
    assign fset             = fi_q[LW +: IX];
    assign fway             = (LW > 0) ? fi_q[AW-1:0] : '0;
    assign unused_addr_bits = ^dmemaddr[1:0];

    function automatic logic [31:0] mk_addr(logic [TW-1:0] t, logic [IX-1:0] s, logic [WOW-1:0] w);
        return (32'(t) << TAG_LSB) | (32'(s) << IX_LSB) | (32'(w) << 2);
    endfunction

    // Tag match and victim choice: first invalid way, otherwise the oldest way
    always_comb begin
        hit_c       = 1'b0;
        hit_way_c   = '0;
        inv_found_c = 1'b0;
        vict_c      = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit_c     = 1'b1;
                hit_way_c = AW'(w);
            end
            if (!inv_found_c && age_q[req_idx][w] == AW'(WAYS - 1)) vict_c = AW'(w);
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!inv_found_c && !valid_q[req_idx][w]) begin
                inv_found_c = 1'b1;
                vict_c      = AW'(w);
            end
        end
    end

    // Next state, burst counters and memory-side outputs
    always_comb begin
        state_d  = state_q;
        wc_d     = wc_q;
        fi_d     = fi_q;
        vway_d   = vway_q;
        mtag_d   = mtag_q;
        midx_d   = midx_q;
        dhit     = 1'b0;
        dmemload = '0;
        flushed  = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;

        last_wc_c     = (wc_q == WOW'(BLOCK_WORDS - 1));
        hit_acc_c     = (state_q == S_IDLE) && !halt && (dmemREN || dmemWEN) && hit_c;
        load_xfer_c   = (state_q == S_LOAD) && !dwait;
        fill_done_c   = load_xfer_c && last_wc_c;
        flush_clean_c = (state_q == S_FLUSH_WB) && !dwait && last_wc_c;
        touch_c       = hit_acc_c || fill_done_c;
        touch_set_c   = hit_acc_c ? req_idx : midx_q;
        touch_way_c   = hit_acc_c ? hit_way_c : vway_q;

        case (state_q)
            S_IDLE: begin
                if (halt) begin
                    fi_d    = '0;
                    state_d = S_FLUSH_CHK;
                end else if (dmemREN || dmemWEN) begin
                    if (hit_c) begin
                        dhit     = 1'b1;
                        dmemload = data_q[req_idx][hit_way_c][req_wo];
                    end else begin
                        vway_d  = vict_c;
                        mtag_d  = req_tag;
                        midx_d  = req_idx;
                        wc_d    = '0;
                        state_d = (valid_q[req_idx][vict_c] && dirty_q[req_idx][vict_c]) ? S_WB : S_LOAD;
                    end
                end
            end
            S_WB: begin
                dWEN   = 1'b1;
                daddr  = mk_addr(tag_q[midx_q][vway_q], midx_q, wc_q);
                dstore = data_q[midx_q][vway_q][wc_q];
                if (!dwait) begin
                    wc_d = last_wc_c ? '0 : WOW'(wc_q + 1'b1);
                    if (last_wc_c) state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                dREN  = 1'b1;
                daddr = mk_addr(mtag_q, midx_q, wc_q);
                if (!dwait) begin
                    wc_d = last_wc_c ? '0 : WOW'(wc_q + 1'b1);
                    if (last_wc_c) state_d = S_IDLE;
                end
            end
            S_FLUSH_CHK: begin
                if (fi_q == FW'(NF)) begin
                    state_d = S_CNT;
                end else if (dirty_q[fset][fway]) begin
                    wc_d    = '0;
                    state_d = S_FLUSH_WB;
                end else begin
                    fi_d = FW'(fi_q + 1'b1);
                end
            end
            S_FLUSH_WB: begin
                dWEN   = 1'b1;
                daddr  = mk_addr(tag_q[fset][fway], fset, wc_q);
                dstore = data_q[fset][fway][wc_q];
                if (!dwait) begin
                    wc_d = last_wc_c ? '0 : WOW'(wc_q + 1'b1);
                    if (last_wc_c) begin
                        fi_d    = FW'(fi_q + 1'b1);
                        state_d = S_FLUSH_CHK;
                    end
                end
            end
            S_CNT: begin
                dWEN   = 1'b1;
                daddr  = HIT_CNT_ADDR;
                dstore = hits_q;
                if (!dwait) state_d = S_HALTED;
            end
            S_HALTED: flushed = 1'b1;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            wc_q    <= '0;
            fi_q    <= '0;
            vway_q  <= '0;
            mtag_q  <= '0;
            midx_q  <= '0;
            hits_q  <= '0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            fi_q    <= fi_d;
            vway_q  <= vway_d;
            mtag_q  <= mtag_d;
            midx_q  <= midx_d;
            if (hit_acc_c) hits_q <= hits_q + 32'd1;
        end
    end

    // Valid/dirty/LRU metadata; ages restart at the way index
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= AW'(w);
                end
            end
        end else begin
            if (hit_acc_c && dmemWEN) dirty_q[req_idx][hit_way_c] <= 1'b1;
            if (fill_done_c) begin
                valid_q[midx_q][vway_q] <= 1'b1;
                dirty_q[midx_q][vway_q] <= 1'b0;
            end
            if (flush_clean_c) dirty_q[fset][fway] <= 1'b0;
            if (touch_c) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (age_q[touch_set_c][w] < age_q[touch_set_c][touch_way_c])
                        age_q[touch_set_c][w] <= AW'(age_q[touch_set_c][w] + 1'b1);
                end
                age_q[touch_set_c][touch_way_c] <= '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (hit_acc_c && dmemWEN) data_q[req_idx][hit_way_c][req_wo] <= dmemstore;
            if (load_xfer_c) data_q[midx_q][vway_q][wc_q] <= dload;
            if (fill_done_c) tag_q[midx_q][vway_q] <= mtag_q;
        end
    end
endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc: default geometry plus a 4-set/4-way/4-word instance.
module tb_dcache_assoc;
    typedef struct packed {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst, halt, dmemREN, dmemWEN, sel;
    logic [31:0] dmemaddr, dmemstore;
    logic [31:0] dload;
    logic        dwait = 1'b0;

    logic        dhit0, flushed0, dren0, dwen0;
    logic [31:0] dmemload0, daddr0, dstore0;
    logic        dhit1, flushed1, dren1, dwen1;
    logic [31:0] dmemload1, daddr1, dstore1;

    logic        dhit_m, flushed_m, dren_m, dwen_m;
    logic [31:0] dmemload_m, daddr_m, dstore_m;

    xfer_t       log_q[$];
    int          wait_len = 0;
    int          wait_left = 0;
    bit          wait_rand = 1'b0;
    int          stab_err = 0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr, prev_data;
    logic        prev_ren, prev_wen;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    dcache_assoc u_dut0 (
        .CLK(clk), .RST(rst | sel), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit0), .dmemload(dmemload0),
        .flushed(flushed0), .dREN(dren0), .dWEN(dwen0), .daddr(daddr0), .dstore(dstore0),
        .dload(dload), .dwait(dwait)
    );

    dcache_assoc #(.SETS(4), .WAYS(4), .BLOCK_WORDS(4)) u_dut1 (
        .CLK(clk), .RST(rst | ~sel), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit1), .dmemload(dmemload1),
        .flushed(flushed1), .dREN(dren1), .dWEN(dwen1), .daddr(daddr1), .dstore(dstore1),
        .dload(dload), .dwait(dwait)
    );

    assign dhit_m     = sel ? dhit1 : dhit0;
    assign flushed_m  = sel ? flushed1 : flushed0;
    assign dren_m     = sel ? dren1 : dren0;
    assign dwen_m     = sel ? dwen1 : dwen0;
    assign dmemload_m = sel ? dmemload1 : dmemload0;
    assign daddr_m    = sel ? daddr1 : daddr0;
    assign dstore_m   = sel ? dstore1 : dstore0;
    assign dload      = 32'hDEAD_0000 + daddr_m;

    function automatic int next_wait();
        return wait_rand ? int'($urandom_range(0, 5)) : wait_len;
    endfunction

    // Memory model: programmable wait states, transfer log, hold-stability monitor
    always @(negedge clk) begin
        if (dren_m || dwen_m) begin
            if (prev_wait && (daddr_m !== prev_addr || dstore_m !== prev_data ||
                              dren_m !== prev_ren || dwen_m !== prev_wen))
                stab_err++;
            if (wait_left > 0) begin
                dwait = 1'b1;
                wait_left--;
            end else begin
                dwait = 1'b0;
                log_q.push_back(xfer_t'{wr: dwen_m, a: daddr_m, d: dstore_m});
                wait_left = next_wait();
            end
            prev_wait = dwait;
            prev_addr = daddr_m;
            prev_data = dstore_m;
            prev_ren  = dren_m;
            prev_wen  = dwen_m;
        end else begin
            dwait     = 1'b0;
            prev_wait = 1'b0;
            wait_left = next_wait();
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic chk_log(input string tag, input int idx, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
        if (idx < log_q.size()) begin
            check({tag, "_wr"}, 32'(log_q[idx].wr), 32'(wr));
            check({tag, "_addr"}, log_q[idx].a, a);
            if (wr) check({tag, "_data"}, log_q[idx].d, d);
        end
    endtask

    task automatic set_wait(input int n);
        wait_len = n;
        @(negedge clk);
    endtask

    // Issue one request and hold it until dhit; lat counts cycles before the hit
    task automatic access(input logic [31:0] a, input logic we, input logic [31:0] d,
                          output logic [31:0] rd, output int lat);
        dmemaddr  = a;
        dmemREN   = ~we;
        dmemWEN   = we;
        dmemstore = d;
        lat       = 0;
        #1;
        while (!dhit_m && lat < 200) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check("access_done", 32'(dhit_m), 32'd1);
        rd = dmemload_m;
        @(negedge clk);
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
    endtask

    task automatic wait_flushed();
        int n = 0;
        while (!flushed_m && n < 600) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("flushed", 32'(flushed_m), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int          lat, base, n;

        rst = 1'b1; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; sel = 1'b0;
        dmemaddr = '0; dmemstore = '0;
        wait_len = 2;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_dren", 32'(dren_m), 32'd0);
        check("rst_dwen", 32'(dwen_m), 32'd0);
        check("rst_dhit", 32'(dhit_m), 32'd0);
        check("rst_flushed", 32'(flushed_m), 32'd0);
        check("rst_daddr", daddr_m, 32'd0);

        // Cold load miss with two wait states per word, then same-block hit
        base = log_q.size();
        access(32'h40, 1'b0, '0, rd, lat);
        check("t1_nxfer", 32'(log_q.size() - base), 32'd2);
        chk_log("t1_r0", base, 1'b0, 32'h40, '0);
        chk_log("t1_r1", base + 1, 1'b0, 32'h44, '0);
        check("t1_data", rd, 32'hDEAD_0040);
        check("t1_lat", 32'(lat), 32'd7);
        access(32'h44, 1'b0, '0, rd, lat);
        check("t1_hit_data", rd, 32'hDEAD_0044);
        check("t1_hit_lat", 32'(lat), 32'd0);

        // Dirty LRU victim is written back before the fill
        set_wait(0);
        access(32'h40, 1'b1, 32'h1111, rd, lat);
        check("t2_store_lat", 32'(lat), 32'd0);
        base = log_q.size();
        access(32'h240, 1'b0, '0, rd, lat);
        check("t2_240_nxfer", 32'(log_q.size() - base), 32'd2);
        chk_log("t2_240_r0", base, 1'b0, 32'h240, '0);
        check("t2_240_lat", 32'(lat), 32'd3);
        base = log_q.size();
        access(32'h440, 1'b0, '0, rd, lat);
        check("t2_440_nxfer", 32'(log_q.size() - base), 32'd4);
        chk_log("t2_wb0", base, 1'b1, 32'h40, 32'h1111);
        chk_log("t2_wb1", base + 1, 1'b1, 32'h44, 32'hDEAD_0044);
        chk_log("t2_rd0", base + 2, 1'b0, 32'h440, '0);
        chk_log("t2_rd1", base + 3, 1'b0, 32'h444, '0);
        check("t2_440_data", rd, 32'hDEAD_0440);
        check("t2_440_lat", 32'(lat), 32'd5);

        // Three dirty frames, then halt: ascending flush and hit-count write
        access(32'h240, 1'b1, 32'hA240, rd, lat);
        access(32'h08, 1'b1, 32'hB008, rd, lat);
        access(32'h3C, 1'b1, 32'hC03C, rd, lat);
        set_wait(1);
        base = log_q.size();
        halt = 1'b1;
        wait_flushed();
        check("t3_nxfer", 32'(log_q.size() - base), 32'd7);
        chk_log("t3_w0", base,     1'b1, 32'h240,  32'hA240);
        chk_log("t3_w1", base + 1, 1'b1, 32'h244,  32'hDEAD_0244);
        chk_log("t3_w2", base + 2, 1'b1, 32'h08,   32'hB008);
        chk_log("t3_w3", base + 3, 1'b1, 32'h0C,   32'hDEAD_000C);
        chk_log("t3_w4", base + 4, 1'b1, 32'h38,   32'hDEAD_0038);
        chk_log("t3_w5", base + 5, 1'b1, 32'h3C,   32'hC03C);
        chk_log("t3_cnt", base + 6, 1'b1, 32'h3100, 32'd8);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("t3_hold_flushed", 32'(flushed_m), 32'd1);
            check("t3_hold_dwen", 32'(dwen_m), 32'd0);
        end

        // Reset in the middle of a fill, then the same address refills
        @(negedge clk);
        rst = 1'b1; halt = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        set_wait(2);
        base = log_q.size();
        dmemaddr = 32'h80; dmemREN = 1'b1;
        n = 0;
        while (log_q.size() == base && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t4_word0", 32'(log_q.size() - base), 32'd1);
        @(negedge clk);
        rst = 1'b1; dmemREN = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t4_dren", 32'(dren_m), 32'd0);
        check("t4_dhit", 32'(dhit_m), 32'd0);
        check("t4_nxfer", 32'(log_q.size() - base), 32'd1);
        base = log_q.size();
        access(32'h80, 1'b0, '0, rd, lat);
        check("t4_refill_nxfer", 32'(log_q.size() - base), 32'd2);
        chk_log("t4_refill_r0", base, 1'b0, 32'h80, '0);
        check("t4_refill_data", rd, 32'hDEAD_0080);
        check("t4_refill_lat", 32'(lat), 32'd7);

        // Halt wins over a hitting load; random waits must not disturb the bus
        access(32'h80, 1'b1, 32'h5555, rd, lat);
        wait_rand = 1'b1;
        base = log_q.size();
        halt = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h80;
        #1;
        check("t5_dhit", 32'(dhit_m), 32'd0);
        @(negedge clk);
        dmemREN = 1'b0;
        wait_flushed();
        check("t5_nxfer", 32'(log_q.size() - base), 32'd3);
        chk_log("t5_w0", base,     1'b1, 32'h80,   32'h5555);
        chk_log("t5_w1", base + 1, 1'b1, 32'h84,   32'hDEAD_0084);
        chk_log("t5_cnt", base + 2, 1'b1, 32'h3100, 32'd2);
        check("t5_stable", 32'(stab_err), 32'd0);

        // Four-way geometry: LRU victim after re-touching the oldest tag
        @(negedge clk);
        halt = 1'b0; rst = 1'b1; sel = 1'b1; wait_rand = 1'b0;
        set_wait(1);
        rst = 1'b0;
        @(negedge clk);
        for (int t = 1; t <= 4; t++) begin
            access(32'(t) << 6, 1'b1, 32'(t), rd, lat);
            check("t6_fill_lat", 32'(lat), 32'd9);
        end
        access(32'h40, 1'b0, '0, rd, lat);
        check("t6_touch_lat", 32'(lat), 32'd0);
        check("t6_touch_data", rd, 32'd1);
        base = log_q.size();
        access(32'h140, 1'b1, 32'd5, rd, lat);
        check("t6_nxfer", 32'(log_q.size() - base), 32'd8);
        check("t6_lat", 32'(lat), 32'd17);
        for (int i = 0; i < 4; i++)
            chk_log("t6_wb", base + i, 1'b1, 32'h80 + 32'(4 * i),
                    (i == 0) ? 32'd2 : 32'hDEAD_0080 + 32'(4 * i));
        for (int i = 0; i < 4; i++)
            chk_log("t6_rd", base + 4 + i, 1'b0, 32'h140 + 32'(4 * i), '0);
        access(32'hC0, 1'b0, '0, rd, lat);
        check("t6_keep3_lat", 32'(lat), 32'd0);
        check("t6_keep3_data", rd, 32'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
